// File: rtl/serial_msg_demux.sv
// serial_msg_demux: decodes framed messages on a 1-bit serial line
// (start 0, address, length, payload MSB first, optional parity) and
// routes each payload to one of NCH parallel channel registers.
// Optional feature: define PARITY_EN to add the even-parity check bit
// and the ERROR path; without it err is tied low.

// One channel register: loads on we, pulses vld for one cycle per load.
module serial_msg_demux_chreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          vld
);
  // channel value holds until its own commit; vld mirrors the write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= we;
      if (we) q <= d;
    end
  end
endmodule

module serial_msg_demux #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int LW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serIn,
  output logic [NCH*DW-1:0]        ch_out,
  output logic [NCH-1:0]           ch_valid,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(NCH)-1:0]   cur_ch,
  output logic                     err
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = (LW > CHW) ? LW : CHW;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_PAR, S_COMMIT, S_ERROR
  } state_t;

`ifdef PARITY_EN
  localparam state_t S_TAIL = S_PAR;
`else
  localparam state_t S_TAIL = S_COMMIT;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     len;
  logic [DW-1:0]     staging;

  logic [DW:0]       stg_sh;
  logic [LW:0]       len_sh;
  logic [CHW:0]      ch_sh;
  logic [DW-1:0]     stg_nxt;
  logic [LW-1:0]     len_nxt;
  logic [CHW-1:0]    ch_nxt;
  logic              last_addr, last_len, last_data;
  logic              frame_end;
  logic              commit_now;
  logic              error_now;
  logic [NCH-1:0]    wr_en;
  logic [DW-1:0]     wr_data;
  logic [NCH-1:0][DW-1:0] ch_q;

  // next-value shifts and end-of-field decodes for the bit sampled this edge
  always_comb begin
    stg_sh    = {staging, serIn};
    len_sh    = {len, serIn};
    ch_sh     = {cur_ch, serIn};
    stg_nxt   = stg_sh[DW-1:0];
    len_nxt   = len_sh[LW-1:0];
    ch_nxt    = ch_sh[CHW-1:0];
    last_addr = (cnt == CW'(CHW - 1));
    last_len  = (cnt == CW'(LW - 1));
    last_data = (cnt == (CW'(len) - CW'(1)));
    frame_end = ((state == S_LEN) && last_len && (len_nxt == '0)) ||
                ((state == S_DATA) && last_data);
  end

`ifdef PARITY_EN
  logic par;
  logic err_q;

  // running XOR over address, length and data bits of the current frame
  always_ff @(posedge clk) begin
    if (rst)
      par <= 1'b0;
    else if (state == S_IDLE)
      par <= 1'b0;
    else if ((state == S_ADDR) || (state == S_LEN) || (state == S_DATA))
      par <= par ^ serIn;
  end

  // parity bit must equal the accumulated XOR for the frame to commit
  always_comb begin
    commit_now = (state == S_PAR) && (serIn == par);
    error_now  = (state == S_PAR) && (serIn != par);
  end

  // err pulses in the cycle after a bad parity bit
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= error_now;
  end
  assign err = err_q;
`else
  // without parity a frame commits as soon as its last payload bit arrives
  always_comb begin
    commit_now = frame_end;
    error_now  = 1'b0;
  end
  assign err = 1'b0;
`endif

  // write strobe and data for the addressed channel; the DATA-state
  // commit folds in the bit being sampled so latency is one cycle
  always_comb begin
    wr_data = (state == S_DATA) ? stg_nxt : staging;
    wr_en   = '0;
    if (commit_now) wr_en[cur_ch] = 1'b1;
  end

  // frame FSM: address/length/data shifting and the 1-cycle end states
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len     <= '0;
      staging <= '0;
      cur_ch  <= '0;
      done    <= 1'b0;
    end else begin
      done <= commit_now | error_now;
      case (state)
        S_IDLE: begin
          if (!serIn) begin
            state   <= S_ADDR;
            staging <= '0;
            cnt     <= '0;
            len     <= '0;
          end
        end
        S_ADDR: begin
          cur_ch <= ch_nxt;
          if (last_addr) begin
            cnt   <= '0;
            state <= S_LEN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LEN: begin
          len <= len_nxt;
          if (last_len) begin
            cnt   <= '0;
            state <= (len_nxt == '0) ? S_TAIL : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          staging <= stg_nxt;
          cnt     <= cnt + CW'(1);
          if (last_data) state <= S_TAIL;
        end
        S_PAR:    state <= commit_now ? S_COMMIT : S_ERROR;
        S_COMMIT: state <= S_IDLE;
        S_ERROR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  serial_msg_demux_chreg #(.DW(DW)) u_ch [NCH-1:0] (
    .clk (clk),
    .rst (rst),
    .we  (wr_en),
    .d   (wr_data),
    .q   (ch_q),
    .vld (ch_valid)
  );

  assign ch_out = ch_q;
endmodule

// File: tb/tb_serial_msg_demux.sv
// Directed bench for serial_msg_demux with NCH=4, DW=8, LW=4.
module tb_serial_msg_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic        serIn;
  logic [31:0] ch_out;
  logic [3:0]  ch_valid;
  logic        done;
  logic        busy;
  logic [1:0]  cur_ch;
  logic        err;

  logic [3:0][7:0] exp_ch;
  int n_assert = 0;
  int n_fail   = 0;

  serial_msg_demux #(.NCH(4), .DW(8), .LW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .serIn    (serIn),
    .ch_out   (ch_out),
    .ch_valid (ch_valid),
    .done     (done),
    .busy     (busy),
    .cur_ch   (cur_ch),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    serIn = b;
    @(posedge clk);
    #1;
  endtask

  // drives one frame; returns 1 cycle after the last bit edge
  task automatic send_frame(input logic [1:0] ch, input int len,
                            input logic [15:0] data, input logic flip);
    logic p;
    logic [3:0] l4;
    l4 = 4'(len);
    p  = ^ch ^ ^l4;
    put_bit(1'b0);
    for (int i = 1; i >= 0; i--) put_bit(ch[i]);
    for (int i = 3; i >= 0; i--) put_bit(l4[i]);
    for (int i = len - 1; i >= 0; i--) begin
      put_bit(data[i]);
      p = p ^ data[i];
    end
`ifdef PARITY_EN
    put_bit(p ^ flip);
`else
    if (flip) p = ~p;
`endif
  endtask

  // commit-cycle checks, then one cycle (line idle) to check pulses clear
  task automatic chk_commit(input string tag, input logic [3:0] vexp, input logic [1:0] cexp);
    chk({tag, "_ch_out"}, ch_out, exp_ch);
    chk({tag, "_valid"}, {28'd0, ch_valid}, {28'd0, vexp});
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cur_ch"}, {30'd0, cur_ch}, {30'd0, cexp});
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    serIn = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_clr"}, {28'd0, ch_valid}, 32'd0);
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    serIn  = 1'b1;
    rst    = 1'b1;
    exp_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_out", ch_out, 32'd0);
    chk("rst_valid", {28'd0, ch_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cur_ch", {30'd0, cur_ch}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (2) put_bit(1'b1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // ch2 <- 1011
    send_frame(2'd2, 4, 16'h000B, 1'b0);
    exp_ch[2] = 8'h0B;
    chk_commit("f_ch2", 4'b0100, 2'd2);

    // ch1 <- FF, then len=0 clears it
    send_frame(2'd1, 8, 16'h00FF, 1'b0);
    exp_ch[1] = 8'hFF;
    chk_commit("f_ch1_ff", 4'b0010, 2'd1);
    send_frame(2'd1, 0, 16'h0000, 1'b0);
    exp_ch[1] = 8'h00;
    chk_commit("f_ch1_len0", 4'b0010, 2'd1);

    // ch3 len=10 keeps last 8 bits; back-to-back ch0 frame follows
    send_frame(2'd3, 10, 16'h035A, 1'b0);
    exp_ch[3] = 8'h5A;
    chk_commit("f_ch3_len10", 4'b1000, 2'd3);
    send_frame(2'd0, 3, 16'h0005, 1'b0);
    exp_ch[0] = 8'h05;
    chk_commit("f_ch0_b2b", 4'b0001, 2'd0);

    // max length 15 to ch0
    send_frame(2'd0, 15, 16'h4ABC, 1'b0);
    exp_ch[0] = 8'hBC;
    chk_commit("f_ch0_len15", 4'b0001, 2'd0);

    // reset during DATA of a ch2 frame
    put_bit(1'b0);
    put_bit(1'b1); put_bit(1'b0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b0); put_bit(1'b0);
    put_bit(1'b1); put_bit(1'b1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    put_bit(1'b1);
    chk("mid_rst_valid", {28'd0, ch_valid}, 32'd0);
    put_bit(1'b1);
    rst = 1'b0;
    exp_ch = '0;
    chk("mid_rst_ch_out", ch_out, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    put_bit(1'b1);
    chk("post_rst_valid", {28'd0, ch_valid}, 32'd0);
    send_frame(2'd2, 2, 16'h0003, 1'b0);
    exp_ch[2] = 8'h03;
    chk_commit("f_ch2_after_rst", 4'b0100, 2'd2);

`ifdef PARITY_EN
    send_frame(2'd1, 4, 16'h0009, 1'b0);
    exp_ch[1] = 8'h09;
    chk_commit("par_good", 4'b0010, 2'd1);
    send_frame(2'd1, 4, 16'h0006, 1'b1);
    chk("par_bad_err", {31'd0, err}, 32'd1);
    chk("par_bad_done", {31'd0, done}, 32'd1);
    chk("par_bad_valid", {28'd0, ch_valid}, 32'd0);
    chk("par_bad_ch_out", ch_out, exp_ch);
    put_bit(1'b1);
    chk("par_bad_err_clr", {31'd0, err}, 32'd0);
    chk("par_bad_idle", {31'd0, busy}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
